ac2_drain: RTL and testbench

AC2_DRAIN -- requirements
Module: ac2_drain

---
 rtl/ac2_drain.sv | 107 ++++++++++
 tb/tb_ac2_drain.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ac2_drain.sv
// Drain unit for the four accumulator result registers. On start it snapshots them,
// pulses the per-register clean-enable, then streams the snapshot out over valid/ready.
module ac2_drain #(
    parameter int M  = 16,
    parameter int Pa = 8,
    parameter int Pw = 4,
    localparam int W = $clog2(M) + Pa + Pw
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] in_0,
    input  logic [W-1:0] in_1,
    input  logic [W-1:0] in_2,
    input  logic [W-1:0] in_3,
    output logic         cl_en,
    output logic [1:0]   w_en,
    output logic         busy,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   out_idx,
    output logic         out_last
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         capture;
    logic [W-1:0] buf_q [4];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: the snapshot buffer is reset on purpose, so a drain aborted by reset
    // can never leak stale words; this small array maps to flops, not RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) buf_q[i] <= '0;
        end else if (capture) begin
            buf_q[0] <= in_0;
            buf_q[1] <= in_1;
            buf_q[2] <= in_2;
            buf_q[3] <= in_3;
        end
    end

    // NOTE: every signal driven here gets a default first, which rules out
    // latch inference on any path through the case statement.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture   = 1'b0;
        cl_en     = 1'b0;
        w_en      = 2'd0;
        busy      = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_idx   = 2'd0;
        out_last  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    cnt_d   = 2'd0;
                    state_d = CLR;
                end
            end
            CLR: begin
                busy  = 1'b1;
                cl_en = 1'b1;
                w_en  = cnt_q;
                // The 2-bit counter wraps to 0 after register 3, ready for SEND.
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) state_d = SEND;
            end
            SEND: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = buf_q[cnt_q];
                out_idx   = cnt_q;
                out_last  = (cnt_q == 2'd3);
                if (out_ready) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ac2_drain.sv
// Self-checking bench for ac2_drain: a queue of expected words is filled when a drain
// is started and emptied as the DUT hands words over.
module tb_ac2_drain;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] in_0 = '0, in_1 = '0, in_2 = '0, in_3 = '0;
    logic         cl_en, busy, out_valid, out_last;
    logic [1:0]   w_en, out_idx;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_data;

    typedef struct packed {
        logic [W-1:0] data;
        logic [1:0]   idx;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    ac2_drain dut (
        .clk(clk), .rst(rst), .start(start),
        .in_0(in_0), .in_1(in_1), .in_2(in_2), .in_3(in_3),
        .cl_en(cl_en), .w_en(w_en), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Drive inputs and request a drain; the start edge is the next rising edge.
    task automatic start_drain(input logic [W-1:0] d0, d1, d2, d3);
        exp_t e;
        in_0 = d0; in_1 = d1; in_2 = d2; in_3 = d3;
        start = 1'b1;
        e.data = d0; e.idx = 2'd0; exp_q.push_back(e);
        e.data = d1; e.idx = 2'd1; exp_q.push_back(e);
        e.data = d2; e.idx = 2'd2; exp_q.push_back(e);
        e.data = d3; e.idx = 2'd3; exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Four clean-enable cycles with w_en 0..3, no output word yet.
    task automatic check_clr(input bit change_in0);
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (cl_en !== 1'b1 || w_en !== 2'(i) || busy !== 1'b1 || out_valid !== 1'b0) begin
                fails++;
                $display("FAIL clr_%0d: cl_en=%b w_en=%0d busy=%b out_valid=%b, want cl_en=1 w_en=%0d busy=1 out_valid=0",
                         i, cl_en, w_en, busy, out_valid, i);
            end
            if (change_in0 && i == 1) in_0 = 16'h1234;
            @(negedge clk);
        end
    endtask

    // Consume words against the scoreboard; optional stall on one index and
    // optional start pulses during SEND and on the final handshake.
    task automatic collect(input int stall_idx, input int stall_len, input bit poke_start,
                           output int words, output int held_cycles);
        int   stalled = 0;
        int   budget  = 0;
        exp_t e;
        words = 0;
        held_cycles = 0;
        while (exp_q.size() > 0 && budget < 40) begin
            budget++;
            e = exp_q[0];
            start = poke_start && (words == 1 || words == 3);
            if (out_valid && int'(out_idx) == stall_idx && stalled < stall_len) begin
                out_ready = 1'b0;
                stalled++;
            end else begin
                out_ready = 1'b1;
            end
            tests++;
            if (out_valid !== 1'b1 || out_data !== e.data || out_idx !== e.idx ||
                out_last !== (e.idx == 2'd3) || cl_en !== 1'b0) begin
                fails++;
                $display("FAIL word_%0d: valid=%b data=%h idx=%0d last=%b cl_en=%b, want valid=1 data=%h idx=%0d last=%b cl_en=0",
                         e.idx, out_valid, out_data, out_idx, out_last, cl_en,
                         e.data, e.idx, (e.idx == 2'd3));
            end
            if (out_valid && int'(out_idx) == stall_idx) held_cycles++;
            if (out_ready) begin
                void'(exp_q.pop_front());
                words++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        out_ready = 1'b1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL collect_timeout: %0d words left, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_idle(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            tests++;
            if (busy !== 1'b0 || cl_en !== 1'b0 || w_en !== 2'd0 || out_valid !== 1'b0 ||
                out_data !== '0 || out_idx !== 2'd0 || out_last !== 1'b0) begin
                fails++;
                $display("FAIL %s_%0d: busy=%b cl_en=%b w_en=%0d valid=%b data=%h idx=%0d last=%b, want all 0",
                         name, i, busy, cl_en, w_en, out_valid, out_data, out_idx, out_last);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #2;
        tests++;
        if (busy !== 1'b0 || cl_en !== 1'b0 || w_en !== 2'd0 || out_valid !== 1'b0 ||
            out_data !== '0 || out_idx !== 2'd0 || out_last !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: busy=%b cl_en=%b w_en=%0d valid=%b data=%h, want all 0",
                     busy, cl_en, w_en, out_valid, out_data);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_idle("post_reset", 2);
    endtask

    task automatic test_basic();
        int w, h;
        start_drain(16'h0011, 16'h0022, 16'hFFF0, 16'h7FFF);
        check_clr(1'b0);
        collect(-1, 0, 1'b0, w, h);
        tests++;
        if (w !== 4) begin
            fails++;
            $display("FAIL basic_count: got %0d words, want 4", w);
        end
        check_idle("basic_idle", 3);
    endtask

    task automatic test_backpressure();
        int w, h;
        start_drain(16'h0011, 16'h0022, 16'hFFF0, 16'h7FFF);
        check_clr(1'b0);
        collect(1, 3, 1'b0, w, h);
        tests++;
        if (w !== 4 || h !== 4) begin
            fails++;
            $display("FAIL backpressure: words=%0d word1_cycles=%0d, want words=4 word1_cycles=4", w, h);
        end
        check_idle("bp_idle", 2);
    endtask

    task automatic test_snapshot();
        int w, h;
        start_drain(16'h0011, 16'h0022, 16'hFFF0, 16'h7FFF);
        check_clr(1'b1);
        collect(-1, 0, 1'b0, w, h);
        check_idle("snap_idle", 2);
    endtask

    task automatic test_start_busy();
        int w, h;
        start_drain(16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D);
        check_clr(1'b0);
        collect(-1, 0, 1'b1, w, h);
        tests++;
        if (w !== 4) begin
            fails++;
            $display("FAIL start_busy_count: got %0d words, want 4", w);
        end
        check_idle("start_busy_idle", 6);
    endtask

    task automatic test_reset_mid();
        start_drain(16'h0011, 16'h0022, 16'hFFF0, 16'h7FFF);
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (cl_en !== 1'b1 || w_en !== 2'd2) begin
            fails++;
            $display("FAIL reset_mid_pre: cl_en=%b w_en=%0d, want cl_en=1 w_en=2", cl_en, w_en);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if (busy !== 1'b0 || cl_en !== 1'b0 || w_en !== 2'd0 || out_valid !== 1'b0 ||
            out_data !== '0 || out_idx !== 2'd0 || out_last !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_async: busy=%b cl_en=%b w_en=%0d valid=%b data=%h, want all 0",
                     busy, cl_en, w_en, out_valid, out_data);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        check_idle("reset_mid_idle", 6);
    endtask

    task automatic test_signed();
        int w, h;
        start_drain(16'h0011, 16'h0022, 16'h8000, 16'h7FFF);
        check_clr(1'b0);
        collect(-1, 0, 1'b0, w, h);
        check_idle("signed_idle", 2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_snapshot();
        test_start_busy();
        test_reset_mid();
        test_signed();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
